// File: rtl/accel_mac_alu.sv
// accel_mac_alu: single-issue ALU with an iterative shift-add multiplier and a MAC accumulator.
// Optional feature: define ACCEL_MAC_ALU_SATURATE_EN to clamp accumulator overflow instead of wrapping.
module accel_mac_alu #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              acc_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    input  logic              out_ready,
    output logic              busy
);

    localparam int SHW = $clog2(DATA_W);

    typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_RELU, OP_MUL, OP_MAC
    } op_t;

    state_t            state, state_nxt;
    op_t               op;
    logic              sign;
    logic [SHW-1:0]    shamt;
    logic [DATA_W-1:0] alu_res;
    logic              accept, is_mult_op, last_iter;
    logic [DATA_W-1:0] mcand, mplier, prod, prod_nxt;
    logic [SHW-1:0]    cnt;
    logic              is_mac;
    logic [ACC_W-1:0]  acc, acc_nxt, acc_sum, prod_ext;

    // NOTE: every always_comb assigns its outputs a default first so no path can infer a latch.
    always_comb begin
        op = OP_ADD;
        case (ALUOp[2:0])
            3'b000: op = OP_ADD;
            3'b001: op = OP_SUB;
            3'b100: op = OP_AND;
            3'b101: op = OP_SLT;
            3'b110: op = OP_MUL;
            3'b010: begin
                case (Funct)
                    6'b00_0000:             op = OP_SLL;
                    6'b00_0010:             op = OP_SRL;
                    6'b00_0011:             op = OP_SRA;
                    6'b10_0000, 6'b10_0001: op = OP_ADD;
                    6'b10_0010, 6'b10_0011: op = OP_SUB;
                    6'b10_0100:             op = OP_AND;
                    6'b10_0101:             op = OP_OR;
                    6'b10_0110:             op = OP_XOR;
                    6'b10_0111:             op = OP_NOR;
                    6'b10_1010, 6'b10_1011: op = OP_SLT;
                    6'b10_1101:             op = OP_MAC;
                    6'b10_1110:             op = OP_RELU;
                    default:                op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
    end

    assign sign  = (ALUOp[2:0] == 3'b010) ? ~Funct[0] : ~ALUOp[3];
    assign shamt = in_a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_SLT:  alu_res = DATA_W'(sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b));
            OP_SLL:  alu_res = in_b << shamt;
            OP_SRL:  alu_res = in_b >> shamt;
            OP_SRA:  alu_res = DATA_W'($signed(in_b) >>> shamt);
            OP_RELU: alu_res = in_a[DATA_W-1] ? '0 : in_a;
            default: alu_res = '0;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign is_mult_op = (op == OP_MUL) || (op == OP_MAC);
    assign last_iter  = (cnt == SHW'(DATA_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = is_mult_op ? ST_MULT : ST_DONE;
            ST_MULT: if (last_iter) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_MULT);
    assign out_valid = (state == ST_DONE);

    // Low product bits are the same for signed and unsigned operands, so one datapath serves both.
    assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
    assign prod_ext = ACC_W'($signed(prod_nxt));
    assign acc_sum  = acc + prod_ext;

`ifdef ACCEL_MAC_ALU_SATURATE_EN
    always_comb begin
        acc_nxt = acc_sum;
        if ((acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]))
            acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_nxt = acc_sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_result <= '0;
            out_zero   <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            prod       <= '0;
            cnt        <= '0;
            is_mac     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A clear on the accept edge lands before the MAC's own update.
                    if (acc_clr) acc <= '0;
                    if (accept) begin
                        if (is_mult_op) begin
                            mcand  <= in_a;
                            mplier <= in_b;
                            prod   <= '0;
                            cnt    <= '0;
                            is_mac <= (op == OP_MAC);
                        end else begin
                            out_result <= alu_res;
                            out_zero   <= (alu_res == '0);
                        end
                    end
                end
                ST_MULT: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    prod   <= prod_nxt;
                    cnt    <= cnt + SHW'(1);
                    if (last_iter) begin
                        if (is_mac) begin
                            acc        <= acc_nxt;
                            out_result <= acc_nxt[DATA_W-1:0];
                            out_zero   <= (acc_nxt[DATA_W-1:0] == '0);
                        end else begin
                            out_result <= prod_nxt;
                            out_zero   <= (prod_nxt == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_mac_alu.sv
// Self-checking bench for accel_mac_alu: table-driven vectors, scoreboard, multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_accel_mac_alu;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, acc_clr, out_valid, out_zero, out_ready, busy;
    logic [3:0]    ALUOp;
    logic [5:0]    Funct;
    logic [DW-1:0] in_a, in_b, out_result;

    always #5 clk = ~clk;

    accel_mac_alu #(.DATA_W(DW), .ACC_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .Funct      (Funct),
        .in_a       (in_a),
        .in_b       (in_b),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic [3:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic        clr;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b, input logic clr,
                                input logic [31:0] e, input int lat);
        vec_t v;
        v.name = n; v.aluop = op; v.funct = f; v.a = a; v.b = b;
        v.clr = clr; v.exp = e; v.lat = lat;
        return v;
    endfunction

    // Scoreboard: pop on every handshake seen half a cycle before the accepting edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, out_result, e.res);
                check({e.name, " zero"}, {31'b0, out_zero}, {31'b0, e.zero});
            end
        end
    end

    task automatic issue(input vec_t v, input bit hold);
        exp_t e;
        int   cycles;
        int   busy_cnt;
        bit   ready_seen;
        @(posedge clk); #1;
        ALUOp = v.aluop; Funct = v.funct; in_a = v.a; in_b = v.b;
        acc_clr = v.clr; in_valid = 1'b1; out_ready = !hold;
        cycles = 0;
        while (!in_ready && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        e.name = v.name; e.res = v.exp; e.zero = (v.exp == 32'd0);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        cycles = 1; busy_cnt = 0; ready_seen = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        check({v.name, " latency"}, cycles, v.lat);
        check({v.name, " busy cycles"}, busy_cnt, (v.lat > 1) ? v.lat - 1 : 0);
        check({v.name, " in_ready while running"}, {31'b0, ready_seen}, 32'd0);
        check({v.name, " busy in DONE"}, {31'b0, busy}, 32'd0);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check({v.name, " held valid"}, {31'b0, out_valid}, 32'd1);
                check({v.name, " held result"}, out_result, v.exp);
            end
            out_ready = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        reset = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        ALUOp = '0; Funct = '0; in_a = '0; in_b = '0;

        vecs.push_back(mk("add",        4'b0000, 6'b00_0000, 32'd5,        32'd7,        1'b0, 32'd12,       1));
        vecs.push_back(mk("sub",        4'b0001, 6'b00_0000, 32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 1));
        vecs.push_back(mk("and op",     4'b0100, 6'b00_0000, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000, 1));
        vecs.push_back(mk("slt op s",   4'b0101, 6'b00_0000, 32'hFFFFFFFE, 32'd1,        1'b0, 32'd1,        1));
        vecs.push_back(mk("slt op u",   4'b1101, 6'b00_0000, 32'hFFFFFFFE, 32'd1,        1'b0, 32'd0,        1));
        vecs.push_back(mk("sll",        4'b0010, 6'b00_0000, 32'd31,       32'd1,        1'b0, 32'h80000000, 1));
        vecs.push_back(mk("srl",        4'b0010, 6'b00_0010, 32'd4,        32'h80000000, 1'b0, 32'h08000000, 1));
        vecs.push_back(mk("sra",        4'b0010, 6'b00_0011, 32'd4,        32'h80000000, 1'b0, 32'hF8000000, 1));
        vecs.push_back(mk("or",         4'b0010, 6'b10_0101, 32'h000000F0, 32'h0000000F, 1'b0, 32'h000000FF, 1));
        vecs.push_back(mk("xor",        4'b0010, 6'b10_0110, 32'h000000FF, 32'h0000000F, 1'b0, 32'h000000F0, 1));
        vecs.push_back(mk("nor",        4'b0010, 6'b10_0111, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1));
        vecs.push_back(mk("slt funct",  4'b0010, 6'b10_1010, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1));
        vecs.push_back(mk("sltu funct", 4'b0010, 6'b10_1011, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1));
        vecs.push_back(mk("relu neg",   4'b0010, 6'b10_1110, 32'h80000000, 32'd9,        1'b0, 32'd0,        1));
        vecs.push_back(mk("relu pos",   4'b0010, 6'b10_1110, 32'd5,        32'd9,        1'b0, 32'd5,        1));
        vecs.push_back(mk("add wrap",   4'b0010, 6'b10_0000, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1));
        vecs.push_back(mk("subu",       4'b0010, 6'b10_0011, 32'd10,       32'd3,        1'b0, 32'd7,        1));
        vecs.push_back(mk("and funct",  4'b0010, 6'b10_0100, 32'h0000FFFF, 32'h00FF00FF, 1'b0, 32'h000000FF, 1));
        vecs.push_back(mk("dflt aluop", 4'b0011, 6'b00_0000, 32'd1,        32'd1,        1'b0, 32'd2,        1));
        vecs.push_back(mk("dflt funct", 4'b0010, 6'b11_1111, 32'd2,        32'd3,        1'b0, 32'd5,        1));
        vecs.push_back(mk("mul 7*-3",   4'b0110, 6'b00_0000, 32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 33));
        vecs.push_back(mk("mul 0*5",    4'b0110, 6'b00_0000, 32'd0,        32'd5,        1'b0, 32'd0,        33));

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",   {31'b0, in_ready},  32'd1);
        check("reset out_valid",  {31'b0, out_valid}, 32'd0);
        check("reset busy",       {31'b0, busy},      32'd0);
        check("reset out_result", out_result,         32'd0);
        check("reset out_zero",   {31'b0, out_zero},  32'd0);
        reset = 1'b0;

        foreach (vecs[i]) issue(vecs[i], 1'b0);

        // MAC chain with a clear, then a held result.
        issue(mk("mac clr 3*4", 4'b0010, 6'b10_1101, 32'd3, 32'd4, 1'b1, 32'd12, 33), 1'b0);
        issue(mk("mac 5*6",     4'b0010, 6'b10_1101, 32'd5, 32'd6, 1'b0, 32'd42, 33), 1'b1);

        // Reset in the middle of a multiply: the operation and accumulator are discarded.
        @(posedge clk); #1;
        ALUOp = 4'b0110; Funct = '0; in_a = 32'd7; in_b = 32'hFFFFFFFD; in_valid = 1'b1;
        check("mid-reset mul in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid-reset busy before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid-reset in_ready", {31'b0, in_ready},  32'd1);
        check("mid-reset busy",     {31'b0, busy},      32'd0);
        check("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid-reset no output", {31'b0, seen}, 32'd0);
        issue(mk("add after reset", 4'b0000, 6'b00_0000, 32'd2, 32'd2, 1'b0, 32'd4, 1), 1'b0);
        issue(mk("mac acc reset",   4'b0010, 6'b10_1101, 32'd1, 32'd1, 1'b0, 32'd1, 33), 1'b0);

        // Accumulator overflow: saturates or wraps depending on the build.
        issue(mk("mac max first", 4'b0010, 6'b10_1101, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h7FFFFFFF, 33), 1'b0);
`ifdef ACCEL_MAC_ALU_SATURATE_EN
        issue(mk("mac max second", 4'b0010, 6'b10_1101, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 33), 1'b0);
`else
        issue(mk("mac max second", 4'b0010, 6'b10_1101, 32'h7FFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFE, 33), 1'b0);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
